key_conditioner: RTL and testbench

//  Input-side partner of the LED-matrix output path: turns the 7 raw board keys into clean events.

---
 rtl/key_conditioner.sv | 89 ++++++++
 tb/tb_key_conditioner.sv | 139 +++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// key_conditioner: synchronises and debounces raw board keys, then emits
// single-cycle press, release, long-press and auto-repeat pulses per key.
module key_conditioner #(
  parameter int N_KEYS         = 7,
  parameter int KEY_ACTIVE_LOW = 1,
  parameter int DEB_CYCLES     = 1_000_000,
  parameter int HOLD_CYCLES    = 25_000_000,
  parameter int REPEAT_CYCLES  = 5_000_000
) (
  input  logic              CLOCK_50,
  input  logic              rst,
  input  logic [N_KEYS-1:0] keys,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic [N_KEYS-1:0] key_repeat
);
  localparam int DW = $clog2(DEB_CYCLES);
  localparam int CW = $clog2(HOLD_CYCLES > REPEAT_CYCLES ? HOLD_CYCLES : REPEAT_CYCLES);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
  localparam logic [DW-1:0] DEB_ONE   = DW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [N_KEYS-1:0] RAW_IDLE = (KEY_ACTIVE_LOW != 0) ? '1 : '0;
  typedef enum logic [1:0] {S_IDLE, S_HELD, S_REPEAT} state_t;
  logic [N_KEYS-1:0] r_sync1, r_sync2, w_pressed;
  // Synchroniser flops reset to the idle pin level so a held key reads as a fresh press.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      r_sync1 <= RAW_IDLE;
      r_sync2 <= RAW_IDLE;
    end else begin
      r_sync1 <= keys;
      r_sync2 <= r_sync1;
    end
  end
  assign w_pressed = (KEY_ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;
  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    logic          r_level, r_press, r_release, r_long, r_repeat;
    logic [DW-1:0] r_deb;
    logic [CW-1:0] r_cnt;
    state_t        r_state;
    logic          w_flip;
    assign w_flip = (w_pressed[k] != r_level) && (r_deb == DEB_LAST);
    // A debounced edge overrides the hold FSM, so release suppresses long/repeat that cycle.
    always_ff @(posedge CLOCK_50) begin
      if (rst) begin
        r_level   <= 1'b0;
        r_deb     <= '0;
        r_cnt     <= '0;
        r_state   <= S_IDLE;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_long    <= 1'b0;
        r_repeat  <= 1'b0;
      end else begin
        r_press   <= w_flip && w_pressed[k];
        r_release <= w_flip && !w_pressed[k];
        r_long    <= 1'b0;
        r_repeat  <= 1'b0;
        r_deb     <= (w_pressed[k] == r_level || w_flip) ? '0 : r_deb + DEB_ONE;
        if (w_flip) begin
          r_level <= w_pressed[k];
          r_state <= w_pressed[k] ? S_HELD : S_IDLE;
          r_cnt   <= '0;
        end else if (r_state == S_HELD) begin
          if (r_cnt == HOLD_LAST) begin
            r_state  <= S_REPEAT;
            r_cnt    <= '0;
            r_long   <= 1'b1;
            r_repeat <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end else if (r_state == S_REPEAT) begin
          r_cnt    <= (r_cnt == REP_LAST) ? '0 : r_cnt + CNT_ONE;
          r_repeat <= (r_cnt == REP_LAST);
        end
      end
    end
    assign key_level[k]   = r_level;
    assign key_press[k]   = r_press;
    assign key_release[k] = r_release;
    assign key_long[k]    = r_long;
    assign key_repeat[k]  = r_repeat;
  end
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: scoreboarded random + directed bench for key_conditioner.
module tb_key_conditioner;
  localparam int N = 7, DEB = 4, HOLD = 20, REP = 8, MAXC = 16384;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] keys = '1;
  logic [N-1:0] key_level, key_press, key_release, key_long, key_repeat;
  key_conditioner #(.N_KEYS(N), .KEY_ACTIVE_LOW(1), .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP)) dut (.CLOCK_50(clk), .rst(rst), .keys(keys), .key_level(key_level),
    .key_press(key_press), .key_release(key_release), .key_long(key_long), .key_repeat(key_repeat));
  always #5 clk = ~clk;
  typedef struct {int cyc; logic [N-1:0] press, rel, lng, rep;} ev_t;
  typedef struct {int cyc; logic [N-1:0] lvl;} lv_t;
  ev_t evq[$];
  lv_t lvq[$];
  int cyc = 0, checks = 0, failures = 0;
  always @(posedge clk) cyc <= cyc + 1;
  // Reference model: level flips once the last DEB sampled raw values all disagree with it;
  // long/repeat follow from elapsed time since the press.
  logic [N-1:0] hist [0:MAXC-1];
  logic [N-1:0] m_lvl = '0;
  int last_rst = 0;
  int m_p [N];
  function automatic logic samp(input int j, input int k);
    return (j <= last_rst) ? 1'b0 : hist[j][k];
  endfunction
  task automatic step(input logic [N-1:0] raw, input logic r);
    int m, d;
    logic all;
    logic [N-1:0] np, nr, nl, nq;
    m = cyc + 1;
    np = '0; nr = '0; nl = '0; nq = '0;
    rst = r;
    keys = ~raw;
    if (r) begin
      last_rst = m;
      m_lvl = '0;
    end else begin
      hist[m] = raw;
      for (int k = 0; k < N; k++) begin
        all = 1'b1;
        for (int j = m - DEB - 1; j <= m - 2; j++) if (samp(j, k) == m_lvl[k]) all = 1'b0;
        if (all) begin
          m_lvl[k] = ~m_lvl[k];
          np[k] = m_lvl[k];
          nr[k] = ~m_lvl[k];
          if (m_lvl[k]) m_p[k] = m;
        end else if (m_lvl[k]) begin
          d = m - m_p[k];
          nl[k] = (d == HOLD);
          nq[k] = (d >= HOLD) && ((d - HOLD) % REP == 0);
        end
      end
    end
    lvq.push_back('{m, m_lvl});
    if ((np | nr | nl | nq) != '0) evq.push_back('{m, np, nr, nl, nq});
    @(negedge clk);
  endtask
  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%b expected=%b", nm, cyc, act, exp);
    end
  endtask
  always @(posedge clk) begin
    ev_t e;
    #1;
    if (lvq.size() > 0 && lvq[0].cyc == cyc) chk("level", key_level, lvq.pop_front().lvl);
    chk("press_and_release", key_press & key_release, '0);
    if ((key_press | key_release | key_long | key_repeat) != '0) begin
      checks++;
      if (evq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event cyc=%0d press=%b rel=%b long=%b rep=%b", cyc, key_press,
          key_release, key_long, key_repeat);
      end else begin
        e = evq.pop_front();
        if (e.cyc != cyc) begin
          failures++;
          $display("FAIL event_cycle actual=%0d expected=%0d", cyc, e.cyc);
        end
        chk("press", key_press, e.press);
        chk("release", key_release, e.rel);
        chk("long", key_long, e.lng);
        chk("repeat", key_repeat, e.rep);
      end
    end else begin
      while (evq.size() > 0 && evq[0].cyc <= cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_event cyc=%0d expected_at=%0d press=%b rel=%b long=%b rep=%b", cyc,
          evq[0].cyc, evq[0].press, evq[0].rel, evq[0].lng, evq[0].rep);
        void'(evq.pop_front());
      end
    end
  end
  initial begin
    int rem [N];
    logic [N-1:0] cur;
    @(negedge clk);
    repeat (3) step('0, 1'b1);
    repeat (5) step('0, 1'b0);
    repeat (12) step(7'h01, 1'b0);
    repeat (12) step('0, 1'b0);
    repeat (3) step(7'h04, 1'b0);
    repeat (10) step('0, 1'b0);
    repeat (36) step(7'h02, 1'b0);
    repeat (15) step('0, 1'b0);
    repeat (66) step(7'h02, 1'b0);
    repeat (15) step('0, 1'b0);
    repeat (10) step(7'h41, 1'b0);
    repeat (10) step('0, 1'b0);
    repeat (16) step(7'h01, 1'b0);
    step(7'h01, 1'b1);
    repeat (20) step(7'h01, 1'b0);
    repeat (10) step('0, 1'b0);
    cur = '0;
    for (int k = 0; k < N; k++) rem[k] = 0;
    for (int i = 0; i < 4000; i++) begin
      for (int k = 0; k < N; k++) begin
        if (rem[k] == 0) begin
          cur[k] = ~cur[k];
          rem[k] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 70);
        end
        rem[k]--;
      end
      step(cur, $urandom_range(0, 999) == 0);
    end
    repeat (30) step('0, 1'b0);
    @(negedge clk);
    checks++;
    if (evq.size() != 0) begin
      failures++;
      $display("FAIL leftover_events actual=%0d expected=0", evq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
